id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection and WB write-through bypass.
//  - Captures decoded ID fields into the IDEX_* register set.
//  - Downstream, the EX-stage forwarding unit consumes IDEX_rs1/IDEX_rs2 and the ALU operand
//    muxes consume IDEX_rs1_data/IDEX_rs2_data.
//  - Inserts bubbles on load-use hazards and on flush.
//  - Freezes IF/PC on load-use hazards and on external stall.
// PARAMETERS
//  XLEN   32  datapath width (pc, register data, immediate)
//  CNT_W  16  stall counter width (present only with ID_EX_STALL_CNT_EN)
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      asynchronous, active-low reset
//  id_valid        in   1      ID holds a real instruction
//  id_pc           in   XLEN   pc of the ID instruction
//  id_rs1, id_rs2  in   5      source register indices
//  id_rd           in   5      destination register index
//  id_uses_rs1/2   in   1      instruction actually reads rs1 / rs2
//  id_rs1_data/2   in   XLEN   register-file read data
//  id_imm          in   XLEN   sign-extended immediate
//  id_alu_op       in   4      ALU operation code
//  id_alu_src      in   1      1 = ALU operand B is the immediate
//  id_reg_write    in   1      control: writes rd
//  id_mem_read     in   1      control: load
//  id_mem_write    in   1      control: store
//  id_mem_to_reg   in   1      control: WB source is memory
//  wb_reg_write    in   1      WB stage writes the register file this cycle
//  wb_rd           in   5      WB destination index
//  wb_data         in   XLEN   WB write data
//  flush           in   1      branch/jump redirect from EX
//  ext_stall       in   1      downstream (memory) busy; freeze the pipe
//  IDEX_* out           registered copies of every id_* field above, plus IDEX_valid (1)
//  pc_write        out  1      PC update enable (combinational)
//  ifid_write      out  1      IF/ID register enable (combinational)
//  load_use_stall  out  1      load-use bubble is being inserted this cycle (combinational)
//  stall_cnt       out  CNT_W  only with ID_EX_STALL_CNT_EN
// BEHAVIOUR
//  - Reset: rst_n=0 asynchronously clears all IDEX_* (including IDEX_valid) to 0.
//  - hazard = IDEX_valid & IDEX_mem_read & (IDEX_rd!=0) & id_valid &
//             ((id_uses_rs1 & id_rs1==IDEX_rd) | (id_uses_rs2 & id_rs2==IDEX_rd))
//  - Per-edge priority, highest first:
//    1. flush: load a bubble; hazard ignored. pc_write=1, ifid_write=1, load_use_stall=0.
//    2. ext_stall: hold all IDEX_*; pc_write=0, ifid_write=0, load_use_stall=0.
//    3. hazard: load a bubble. pc_write=0, ifid_write=0, load_use_stall=1.
//       The ID instruction is re-presented next cycle, so the stall lasts exactly 1 cycle per load.
//    4. else: load all id_* fields; IDEX_valid <= id_valid; pc_write=1, ifid_write=1.
//  - Bubble: IDEX_valid, IDEX_reg_write, IDEX_mem_read, IDEX_mem_write, IDEX_mem_to_reg,
//    IDEX_rd, IDEX_rs1, IDEX_rs2 all 0; data fields 0.
//    With all these 0, the downstream forwarding unit never matches a bubble.
//  - WB write-through applies on load (case 4) and per operand:
//    if wb_reg_write & wb_rd!=0 & wb_rd==id_rs1, IDEX_rs1_data <= wb_data instead of id_rs1_data.
//    rs2 is handled the same way.
//  - Hold refresh applies during ext_stall (case 2): if wb_reg_write & wb_rd!=0 & wb_rd==IDEX_rs1,
//    IDEX_rs1_data <= wb_data. rs2 is handled the same way.
//    This keeps operands valid after the producer retires past WB.
//  - Register x0 is never bypassed or refreshed.
//  - Latency: 1 cycle, ID -> IDEX_*.
//  - pc_write, ifid_write and load_use_stall are purely combinational.
//    During reset they evaluate with IDEX_valid=0, giving pc_write=1, ifid_write=1, load_use_stall=0.
//  - Reset asserted mid-stall: all state is cleared at once; no pending bubble survives.
// CONFIGURATION
//  ID_EX_STALL_CNT_EN
//   - Defined: the stall_cnt port exists. It resets to 0 and increments on every clk edge
//     where load_use_stall=1. It saturates at all-ones; no wrap.
//   - Undefined: neither the port nor the counter exists. All other behaviour is identical.
// TESTING
//  1. Load x5 in IDEX (mem_read=1, rd=5), ID reads rs1=5 with uses_rs1=1
//     -> load_use_stall=1, pc_write=0; next cycle IDEX_valid=0, IDEX_rd=0;
//     following cycle the ID instruction loads normally.
//  2. Same as 1 but uses_rs1=0, or IDEX_rd=0 -> no stall; instruction loads the next cycle.
//  3. Hazard and flush in the same cycle -> bubble loaded, pc_write=1, load_use_stall=0.
//  4. ext_stall held 3 cycles while wb writes rd=7, data 0xDEADBEEF, and IDEX_rs2=7
//     -> IDEX_rs2_data=0xDEADBEEF; all other IDEX_* unchanged.
//  5. ID reads rs1=9 while wb writes x9=0x1234 -> IDEX_rs1_data=0x1234.
//     With wb_rd=0: no bypass is applied.
//  6. Assert rst_n=0 mid-operation, between clock edges -> all IDEX_* are 0 immediately.
//     With ID_EX_STALL_CNT_EN: after two separate load-use stalls, stall_cnt=2.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and WB write-through bypass.
// Latency: 1 cycle from ID to IDEX_*. pc_write, ifid_write and load_use_stall are combinational.
// Backpressure: ext_stall holds IDEX_* and freezes IF/PC; a load-use hazard inserts one bubble.
//
// Ports: clk/rst_n (async active-low); id_* decoded ID fields; wb_* write-back port;
//        flush / ext_stall pipeline control; IDEX_* registered ID fields plus IDEX_valid;
//        pc_write / ifid_write / load_use_stall front-end control.
// Optional feature: define ID_EX_STALL_CNT_EN to add the saturating stall_cnt output.
module id_ex_stage #(
  parameter int XLEN = 32
`ifdef ID_EX_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ext_stall,
  output logic            IDEX_valid,
  output logic [XLEN-1:0] IDEX_pc,
  output logic [4:0]      IDEX_rs1,
  output logic [4:0]      IDEX_rs2,
  output logic [4:0]      IDEX_rd,
  output logic            IDEX_uses_rs1,
  output logic            IDEX_uses_rs2,
  output logic [XLEN-1:0] IDEX_rs1_data,
  output logic [XLEN-1:0] IDEX_rs2_data,
  output logic [XLEN-1:0] IDEX_imm,
  output logic [3:0]      IDEX_alu_op,
  output logic            IDEX_alu_src,
  output logic            IDEX_reg_write,
  output logic            IDEX_mem_read,
  output logic            IDEX_mem_write,
  output logic            IDEX_mem_to_reg,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            load_use_stall
`ifdef ID_EX_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
  } idex_t;

  idex_t idex_q, idex_d;
  logic  hazard;
  logic  wb_wr_nz;

  always_comb begin
    // x0 is never a bypass source or a hazard target.
    wb_wr_nz = wb_reg_write & (wb_rd != 5'd0);
    hazard   = idex_q.valid & idex_q.mem_read & (idex_q.rd != 5'd0) & id_valid &
               ((id_uses_rs1 & (id_rs1 == idex_q.rd)) |
                (id_uses_rs2 & (id_rs2 == idex_q.rd)));

    idex_d         = idex_q;
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    load_use_stall = 1'b0;

    if (flush) begin
      // A bubble is all-zero: no valid, no controls, no register indices.
      idex_d = '0;
    end else if (ext_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      // Refresh held operands when their producer retires during the stall.
      if (wb_wr_nz && (wb_rd == idex_q.rs1)) idex_d.rs1_data = wb_data;
      if (wb_wr_nz && (wb_rd == idex_q.rs2)) idex_d.rs2_data = wb_data;
    end else if (hazard) begin
      idex_d         = '0;
      pc_write       = 1'b0;
      ifid_write     = 1'b0;
      load_use_stall = 1'b1;
    end else begin
      idex_d.valid      = id_valid;
      idex_d.pc         = id_pc;
      idex_d.rs1        = id_rs1;
      idex_d.rs2        = id_rs2;
      idex_d.rd         = id_rd;
      idex_d.uses_rs1   = id_uses_rs1;
      idex_d.uses_rs2   = id_uses_rs2;
      // Write-through: the register file read misses the value written this cycle.
      idex_d.rs1_data   = (wb_wr_nz && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
      idex_d.rs2_data   = (wb_wr_nz && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
      idex_d.imm        = id_imm;
      idex_d.alu_op     = id_alu_op;
      idex_d.alu_src    = id_alu_src;
      idex_d.reg_write  = id_reg_write;
      idex_d.mem_read   = id_mem_read;
      idex_d.mem_write  = id_mem_write;
      idex_d.mem_to_reg = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign IDEX_valid      = idex_q.valid;
  assign IDEX_pc         = idex_q.pc;
  assign IDEX_rs1        = idex_q.rs1;
  assign IDEX_rs2        = idex_q.rs2;
  assign IDEX_rd         = idex_q.rd;
  assign IDEX_uses_rs1   = idex_q.uses_rs1;
  assign IDEX_uses_rs2   = idex_q.uses_rs2;
  assign IDEX_rs1_data   = idex_q.rs1_data;
  assign IDEX_rs2_data   = idex_q.rs2_data;
  assign IDEX_imm        = idex_q.imm;
  assign IDEX_alu_op     = idex_q.alu_op;
  assign IDEX_alu_src    = idex_q.alu_src;
  assign IDEX_reg_write  = idex_q.reg_write;
  assign IDEX_mem_read   = idex_q.mem_read;
  assign IDEX_mem_write  = idex_q.mem_write;
  assign IDEX_mem_to_reg = idex_q.mem_to_reg;

`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of inserted load-use bubbles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use_stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } idex_m_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_alu_src;
  logic id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [3:0] id_alu_op;
  logic wb_reg_write, flush, ext_stall;

  logic IDEX_valid, IDEX_uses_rs1, IDEX_uses_rs2, IDEX_alu_src;
  logic IDEX_reg_write, IDEX_mem_read, IDEX_mem_write, IDEX_mem_to_reg;
  logic [31:0] IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm;
  logic [4:0] IDEX_rs1, IDEX_rs2, IDEX_rd;
  logic [3:0] IDEX_alu_op;
  logic pc_write, ifid_write, load_use_stall;
`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad = 0;
  idex_m_t m;          // model of the IDEX register contents
  int unsigned m_cnt;  // model of the stall counter
  idex_m_t obs;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ext_stall(ext_stall),
    .IDEX_valid(IDEX_valid), .IDEX_pc(IDEX_pc), .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2),
    .IDEX_rd(IDEX_rd), .IDEX_uses_rs1(IDEX_uses_rs1), .IDEX_uses_rs2(IDEX_uses_rs2),
    .IDEX_rs1_data(IDEX_rs1_data), .IDEX_rs2_data(IDEX_rs2_data), .IDEX_imm(IDEX_imm),
    .IDEX_alu_op(IDEX_alu_op), .IDEX_alu_src(IDEX_alu_src), .IDEX_reg_write(IDEX_reg_write),
    .IDEX_mem_read(IDEX_mem_read), .IDEX_mem_write(IDEX_mem_write),
    .IDEX_mem_to_reg(IDEX_mem_to_reg),
    .pc_write(pc_write), .ifid_write(ifid_write), .load_use_stall(load_use_stall)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always_comb begin
    obs = '{valid: IDEX_valid, pc: IDEX_pc, rs1: IDEX_rs1, rs2: IDEX_rs2, rd: IDEX_rd,
            uses_rs1: IDEX_uses_rs1, uses_rs2: IDEX_uses_rs2,
            rs1_data: IDEX_rs1_data, rs2_data: IDEX_rs2_data, imm: IDEX_imm,
            alu_op: IDEX_alu_op, alu_src: IDEX_alu_src, reg_write: IDEX_reg_write,
            mem_read: IDEX_mem_read, mem_write: IDEX_mem_write, mem_to_reg: IDEX_mem_to_reg};
  end

  // ---------------- reference model ----------------
  // Does the instruction in ID need the value a load in EX has not produced yet?
  function automatic logic model_hazard(idex_m_t s);
    logic needs_ld;
    if (!(s.valid && s.mem_read) || s.rd == 5'd0 || !id_valid) return 1'b0;
    needs_ld = (id_uses_rs1 && id_rs1 == s.rd) || (id_uses_rs2 && id_rs2 == s.rd);
    return needs_ld;
  endfunction

  // Expected {pc_write, ifid_write, load_use_stall}.
  function automatic logic [2:0] model_ctrl(idex_m_t s);
    if (flush)            return 3'b110;
    if (ext_stall)        return 3'b000;
    if (model_hazard(s))  return 3'b001;
    return 3'b110;
  endfunction

  // Value written to register r this cycle by WB, else the register-file value rf.
  function automatic logic [31:0] wb_view(logic [4:0] r, logic [31:0] rf);
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == r) return wb_data;
    return rf;
  endfunction

  function automatic idex_m_t model_next(idex_m_t s);
    idex_m_t n;
    if (flush || (!ext_stall && model_hazard(s))) return '0;
    if (ext_stall) begin
      n = s;
      n.rs1_data = wb_view(s.rs1, s.rs1_data);
      n.rs2_data = wb_view(s.rs2, s.rs2_data);
      return n;
    end
    n = '{valid: id_valid, pc: id_pc, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
          uses_rs1: id_uses_rs1, uses_rs2: id_uses_rs2,
          rs1_data: wb_view(id_rs1, id_rs1_data), rs2_data: wb_view(id_rs2, id_rs2_data),
          imm: id_imm, alu_op: id_alu_op, alu_src: id_alu_src, reg_write: id_reg_write,
          mem_read: id_mem_read, mem_write: id_mem_write, mem_to_reg: id_mem_to_reg};
    return n;
  endfunction

  // One clock edge: advance the model with the inputs present just before the edge.
  task automatic tick();
    idex_m_t nxt;
    logic [2:0] c;
    nxt = model_next(m);
    c = model_ctrl(m);
    @(posedge clk);
    m = nxt;
    if (c[0] && m_cnt != 32'hFFFF) m_cnt = m_cnt + 1;
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_alu_op = 0; id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0; flush = 0; ext_stall = 0;
  endtask

  task automatic drive_load(logic [4:0] rd);
    idle_inputs();
    id_valid = 1; id_pc = 32'h100; id_rd = rd; id_rs1 = 5'd1; id_uses_rs1 = 1;
    id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1; id_imm = 32'h8;
  endtask

  task automatic drive_consumer(logic [4:0] rs1, logic use1);
    idle_inputs();
    id_valid = 1; id_pc = 32'h104; id_rs1 = rs1; id_uses_rs1 = use1; id_rs2 = 5'd2;
    id_uses_rs2 = 1; id_rd = 5'd6; id_reg_write = 1; id_rs1_data = 32'h11; id_rs2_data = 32'h22;
    id_alu_op = 4'h3;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    m = '0; m_cnt = 0;
    #3;
    total++; if (obs !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", obs); end
    total++; if ({pc_write, ifid_write, load_use_stall} !== 3'b110) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=110", {pc_write, ifid_write, load_use_stall}); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_load_use();
    idle_inputs(); tick();
    drive_load(5'd5); tick();
    drive_consumer(5'd5, 1'b1); #1;
    total++; if (load_use_stall !== 1'b1 || pc_write !== 1'b0 || ifid_write !== 1'b0) begin
      bad++; $display("FAIL lu_ctrl got=%b exp=001", {pc_write, ifid_write, load_use_stall}); end
    tick();
    total++; if (IDEX_valid !== 1'b0 || IDEX_rd !== 5'd0 || obs !== '0) begin
      bad++; $display("FAIL lu_bubble got=%h exp=0", obs); end
    total++; if (load_use_stall !== 1'b0 || pc_write !== 1'b1) begin
      bad++; $display("FAIL lu_one_cycle got=%b exp=110", {pc_write, ifid_write, load_use_stall}); end
    tick();
    total++; if (IDEX_valid !== 1'b1 || IDEX_rd !== 5'd6 || obs !== m) begin
      bad++; $display("FAIL lu_reload got=%h exp=%h", obs, m); end
  endtask

  task automatic test_no_stall();
    idle_inputs(); tick();
    drive_load(5'd5); tick();
    drive_consumer(5'd5, 1'b0); #1;
    total++; if (load_use_stall !== 1'b0 || pc_write !== 1'b1) begin
      bad++; $display("FAIL nouse_ctrl got=%b exp=110", {pc_write, ifid_write, load_use_stall}); end
    tick();
    total++; if (IDEX_valid !== 1'b1 || IDEX_rd !== 5'd6 || obs !== m) begin
      bad++; $display("FAIL nouse_load got=%h exp=%h", obs, m); end
    drive_load(5'd0); tick();
    drive_consumer(5'd0, 1'b1); #1;
    total++; if (load_use_stall !== 1'b0 || ifid_write !== 1'b1) begin
      bad++; $display("FAIL rd0_ctrl got=%b exp=110", {pc_write, ifid_write, load_use_stall}); end
    tick();
    total++; if (IDEX_valid !== 1'b1 || obs !== m) begin
      bad++; $display("FAIL rd0_load got=%h exp=%h", obs, m); end
  endtask

  task automatic test_flush_hazard();
    idle_inputs(); tick();
    drive_load(5'd5); tick();
    drive_consumer(5'd5, 1'b1); flush = 1; #1;
    total++; if ({pc_write, ifid_write, load_use_stall} !== 3'b110) begin
      bad++; $display("FAIL flush_ctrl got=%b exp=110", {pc_write, ifid_write, load_use_stall}); end
    tick();
    total++; if (obs !== '0) begin bad++; $display("FAIL flush_bubble got=%h exp=0", obs); end
  endtask

  task automatic test_ext_stall();
    idex_m_t snap, want;
    idle_inputs(); tick();
    id_valid = 1; id_pc = 32'h200; id_rs1 = 5'd2; id_rs2 = 5'd7; id_uses_rs1 = 1;
    id_uses_rs2 = 1; id_rd = 5'd3; id_rs1_data = 32'hAAAA; id_rs2_data = 32'h1111;
    id_imm = 32'hFFFF_FFF0; id_alu_op = 4'h5; id_reg_write = 1;
    tick();
    snap = obs;
    for (int i = 0; i < 3; i++) begin
      id_pc = $urandom; id_rs1 = 5'd7; id_rd = 5'd9; id_rs1_data = $urandom;
      ext_stall = 1; wb_reg_write = 1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF; #1;
      total++; if ({pc_write, ifid_write, load_use_stall} !== 3'b000) begin
        bad++; $display("FAIL stall_ctrl got=%b exp=000", {pc_write, ifid_write, load_use_stall}); end
      tick();
    end
    want = snap; want.rs2_data = 32'hDEADBEEF;
    total++; if (IDEX_rs2_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL stall_refresh got=%h exp=deadbeef", IDEX_rs2_data); end
    total++; if (obs !== want) begin bad++; $display("FAIL stall_hold got=%h exp=%h", obs, want); end
  endtask

  task automatic test_wb_bypass();
    idle_inputs(); tick();
    id_valid = 1; id_rs1 = 5'd9; id_uses_rs1 = 1; id_rs1_data = 32'hAAAA; id_rd = 5'd4;
    wb_reg_write = 1; wb_rd = 5'd9; wb_data = 32'h1234;
    tick();
    total++; if (IDEX_rs1_data !== 32'h1234) begin
      bad++; $display("FAIL bypass_rs1 got=%h exp=1234", IDEX_rs1_data); end
    id_rs1 = 5'd0; id_rs1_data = 32'hBBBB; wb_rd = 5'd0; wb_data = 32'h5678;
    tick();
    total++; if (IDEX_rs1_data !== 32'hBBBB) begin
      bad++; $display("FAIL bypass_x0 got=%h exp=bbbb", IDEX_rs1_data); end
  endtask

  task automatic test_random();
    logic [2:0] c;
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 3) != 0); id_pc = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_alu_op = 4'($urandom); id_alu_src = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_read = 1'($urandom); id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
      wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      flush = ($urandom_range(0, 9) == 0); ext_stall = ($urandom_range(0, 5) == 0);
      #1;
      c = model_ctrl(m);
      total++; if ({pc_write, ifid_write, load_use_stall} !== c) begin
        bad++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", i, {pc_write, ifid_write, load_use_stall}, c); end
      tick();
      total++; if (obs !== m) begin bad++; $display("FAIL rnd_idex cyc=%0d got=%h exp=%h", i, obs, m); end
`ifdef ID_EX_STALL_CNT_EN
      total++; if (stall_cnt !== 16'(m_cnt)) begin
        bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, m_cnt); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs(); tick();
    drive_load(5'd5); tick();
    drive_consumer(5'd5, 1'b1); #2;
    rst_n = 0; #1;
    m = '0; m_cnt = 0;
    total++; if (obs !== '0) begin bad++; $display("FAIL rst_mid got=%h exp=0", obs); end
    total++; if ({pc_write, ifid_write, load_use_stall} !== 3'b110) begin
      bad++; $display("FAIL rst_mid_ctrl got=%b exp=110", {pc_write, ifid_write, load_use_stall}); end
`ifdef ID_EX_STALL_CNT_EN
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", stall_cnt); end
`endif
    @(negedge clk); rst_n = 1;
    tick();
    total++; if (obs !== m || IDEX_valid !== 1'b1) begin
      bad++; $display("FAIL rst_mid_after got=%h exp=%h", obs, m); end
  endtask

`ifdef ID_EX_STALL_CNT_EN
  task automatic test_stall_cnt();
    for (int k = 0; k < 2; k++) begin
      idle_inputs(); tick();
      drive_load(5'd5); tick();
      drive_consumer(5'd5, 1'b1); tick();
      tick();
    end
    idle_inputs(); tick();
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL stall_cnt got=%0d exp=2", stall_cnt); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_flush_hazard();
    test_ext_stall();
    test_wb_bypass();
    test_random();
    test_reset_mid();
`ifdef ID_EX_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
